// File: rtl/muldiv_sched.sv
// Iterative 32x32 multiply / divide sequencer for the EX stage.
// One shift-add or restoring-divide step per cycle; the result is presented for a single DONE cycle.
module muldiv_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_DIV_RUN,
    ST_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] breg;
  logic        is_div, neg_q, neg_r, dz;

  logic        op_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] prod, prod_neg;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign b_mag     = (op_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

  always_comb begin
    mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, breg} : 33'd0);
    rem_sh   = {acc_hi[31:0], acc_lo[31]};
    div_diff = {1'b0, rem_sh} - {2'b00, breg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!op[1])              state_nxt = ST_MUL_RUN;
            else if (src_b == '0)    state_nxt = ST_DONE;
            else                     state_nxt = ST_DIV_RUN;
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          if (cnt == 6'd31) state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // acc_hi:acc_lo is the shifting product in MUL_RUN and remainder:quotient in DIV_RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      breg   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= op_signed & (src_a[31] ^ src_b[31]);
            neg_r  <= op_signed & src_a[31];
            dz     <= op[1] & (src_b == '0);
            if (op[1] && src_b == '0) begin
              acc_hi <= {1'b0, src_a};
              acc_lo <= '1;
              breg   <= '0;
            end else begin
              acc_hi <= '0;
              acc_lo <= op[1] ? a_mag : b_mag;
              breg   <= op[1] ? b_mag : a_mag;
            end
          end
        end
        ST_MUL_RUN: begin
          cnt    <= cnt + 6'd1;
          acc_hi <= {1'b0, mul_sum[32:1]};
          acc_lo <= {mul_sum[0], acc_lo[31:1]};
        end
        ST_DIV_RUN: begin
          cnt <= cnt + 6'd1;
          if (!div_diff[33]) begin
            acc_hi <= {1'b0, div_diff[31:0]};
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= {1'b0, rem_sh[31:0]};
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign prod     = {acc_hi[31:0], acc_lo};
  assign prod_neg = ~prod + 64'd1;

  always_comb begin
    stallreq = ~rst & (((state == ST_IDLE) & start & ~flush) |
                       (state == ST_MUL_RUN) | (state == ST_DIV_RUN));
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    hi_we    = done;
    lo_we    = done;
    div_zero = done & dz;
    hi_wdata = '0;
    lo_wdata = '0;
    if (done) begin
      if (!is_div) begin
        {hi_wdata, lo_wdata} = neg_q ? prod_neg : prod;
      end else if (dz) begin
        hi_wdata = acc_hi[31:0];
        lo_wdata = acc_lo;
      end else begin
        lo_wdata = neg_q ? (~acc_lo + 32'd1) : acc_lo;
        hi_wdata = neg_r ? (~acc_hi[31:0] + 32'd1) : acc_hi[31:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: issued ops push expected HI/LO and due cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stallreq, busy, done, hi_we, lo_we, div_zero;
  logic [31:0] hi_wdata, lo_wdata;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  muldiv_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stallreq (stallreq),
    .busy     (busy),
    .done     (done),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("hi_wdata", hi_wdata, e.hi);
        chk("lo_wdata", lo_wdata, e.lo);
        chk("hi_we", {31'd0, hi_we}, 32'd1);
        chk("lo_we", {31'd0, lo_we}, 32'd1);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Cycle after acceptance edge T: DONE is observed after edge T+32, or after edge T on divide-by-zero.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input logic hold);
    int unsigned lat;
    int unsigned t;
    lat = edz ? 0 : 32;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 chk("stall_on_start", {31'd0, stallreq}, 32'd1);
    @(posedge clk);
    #1;
    t = cyc;
    sb.push_back('{eh, el, edz, t + lat});
    if (!hold) start = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      chk("stall_run", {31'd0, stallreq}, 32'd1);
      chk("busy_run", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("stall_done", {31'd0, stallreq}, 32'd0);
    chk("busy_done", {31'd0, busy}, 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1 chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stallreq"}, {31'd0, stallreq}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_we"}, {30'd0, hi_we, lo_we}, 32'd0);
    chk({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_hi"}, hi_wdata, 32'd0);
    chk({tag, "_lo"}, lo_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    issue(2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
    issue(2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b0);
    issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    issue(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    issue(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0);

    // flush at edge T+10 of a mult: no result, pipeline released
    @(negedge clk);
    op = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 chk("flush_stallreq", {31'd0, stallreq}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    repeat (40) @(posedge clk);
    issue(2'b01, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, 1'b0);

    // asynchronous reset mid-divide with start still asserted
    @(negedge clk);
    op = 2'b10; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("midop_rst");
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    issue(2'b10, 32'h00000064, 32'h00000003, 32'h00000001, 32'h00000021, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_done: got %0d pending results expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
